// File: rtl/seg7_scan_reader_if.sv
// Multiplexed 7-segment display bus plus the decoded-value side of the scan reader.
// master = panel/display driver side, slave = the reader.
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              SEG;
    logic [NUM_DIGITS-1:0]   DIG;
    logic [4*NUM_DIGITS-1:0] VALUE;
    logic                    VALID;
    logic                    ERR;

    modport master (output SEG, DIG, input VALUE, VALID, ERR);
    modport slave  (input SEG, DIG, output VALUE, VALID, ERR);
endinterface

// File: rtl/seg7_scan_reader.sv
// Decodes a scanned 7-segment bus back to digits and publishes frames stable over MATCH_FRAMES scans.
// Optional macro SEG7_HEX_EN: also accept the A..F glyphs as valid nibbles.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int MATCH_FRAMES  = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    seg7_scan_reader_if.slave bus
);
    localparam int          ND   = NUM_DIGITS;
    localparam logic [7:0]  LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  MF   = 4'(MATCH_FRAMES);

    typedef enum logic [1:0] {WAIT, SETTLE, CAPTURE, HOLD} state_t;

    state_t            state, state_n, start_st;
    logic [7:0]        cnt, cnt_n;
    logic [ND-1:0]     prev_dig, mask;
    logic [4*ND-1:0]   frame, prev_good, value;
    logic [3:0]        match, match_n, nib;
    logic              bad, valid, err, cap, nib_ok;
    logic              onehot, changed, mask_full, publish;

    // {ok, nibble}; anything outside the table, blank included, is rejected
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = 5'h10;
            7'b0110000: decode = 5'h11;
            7'b1101101: decode = 5'h12;
            7'b1111001: decode = 5'h13;
            7'b0110011: decode = 5'h14;
            7'b1011011: decode = 5'h15;
            7'b1011111: decode = 5'h16;
            7'b1110000: decode = 5'h17;
            7'b1111111: decode = 5'h18;
            7'b1111011: decode = 5'h19;
`ifdef SEG7_HEX_EN
            7'b1110111: decode = 5'h1A;
            7'b0011111: decode = 5'h1B;
            7'b1001110: decode = 5'h1C;
            7'b0111101: decode = 5'h1D;
            7'b1001111: decode = 5'h1E;
            7'b1000111: decode = 5'h1F;
`endif
            default:    decode = 5'h00;
        endcase
    endfunction

    assign {nib_ok, nib} = decode(bus.SEG);
    assign onehot        = $onehot(bus.DIG);
    assign changed       = bus.DIG != prev_dig;
    assign start_st      = (SETTLE_CYCLES == 1) ? CAPTURE : SETTLE;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap     = 1'b0;
        case (state)
            WAIT: begin
                cnt_n = '0;
                if (onehot) state_n = start_st;
            end
            SETTLE: begin
                if (changed) begin
                    cnt_n   = '0;
                    state_n = onehot ? start_st : WAIT;
                end else begin
                    cnt_n = cnt + 8'd1;
                    if (cnt_n == LAST) state_n = CAPTURE;
                end
            end
            CAPTURE, HOLD: begin
                cap = (state == CAPTURE);
                if (changed) begin
                    cnt_n   = '0;
                    state_n = onehot ? start_st : WAIT;
                end else begin
                    state_n = HOLD;
                end
            end
            default: state_n = WAIT;
        endcase
    end

    // Frame evaluation runs the cycle after the last capture fills the mask
    assign mask_full = &mask;
    always_comb begin
        match_n = 4'd1;
        if (bad)                     match_n = '0;
        else if (frame == prev_good) match_n = (match == MF) ? match : match + 4'd1;
    end
    assign publish = mask_full && !bad && (match_n == MF) && (frame != value);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= WAIT;
            cnt       <= '0;
            prev_dig  <= '0;
            mask      <= '0;
            bad       <= 1'b0;
            match     <= '0;
            prev_good <= '0;
            value     <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            prev_dig <= bus.DIG;
            valid    <= 1'b0;
            err      <= 1'b0;
            if (mask_full) begin
                mask  <= '0;
                bad   <= 1'b0;
                match <= match_n;
                err   <= bad;
                if (!bad) prev_good <= frame;
                if (publish) begin
                    value <= frame;
                    valid <= 1'b1;
                end
            end else if (cap) begin
                mask <= mask | prev_dig;
                if (!nib_ok) bad <= 1'b1;
            end
        end
    end

    // prev_dig still holds the settled select during the CAPTURE cycle
    for (genvar i = 0; i < ND; i++) begin : g_nib
        always_ff @(posedge CLK) begin
            if (!RST_N)                  frame[4*i +: 4] <= '0;
            else if (cap && prev_dig[i]) frame[4*i +: 4] <= nib;
        end
    end

    assign bus.VALUE = value;
    assign bus.VALID = valid;
    assign bus.ERR   = err;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: table of scan vectors plus hand sequences for
// the 50-cycle multi-select hold, mid-frame reset and exact VALID/ERR latency.
module tb_seg7_scan_reader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_reader_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_reader #(.NUM_DIGITS(4), .SETTLE_CYCLES(8), .MATCH_FRAMES(2)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0][6:0] segs;
        int              hold;
        int              frames;
        logic [15:0]     exp_value;
        int              exp_valid;
        int              exp_err;
    } vec_t;

    vec_t tbl [10];
    int   n_vec = 0, n_bad = 0;
    int   valid_cnt, err_cnt, both_cnt = 0, valid_k, err_k;

    function automatic logic [6:0] pat(input logic [3:0] n);
        case (n)
            4'd0: pat = 7'b1111110;  4'd1: pat = 7'b0110000;
            4'd2: pat = 7'b1101101;  4'd3: pat = 7'b1111001;
            4'd4: pat = 7'b0110011;  4'd5: pat = 7'b1011011;
            4'd6: pat = 7'b1011111;  4'd7: pat = 7'b1110000;
            4'd8: pat = 7'b1111111;  4'd9: pat = 7'b1111011;
            default: pat = 7'b0000000;
        endcase
    endfunction

    function automatic logic [3:0][6:0] s4(input logic [3:0] d3, d2, d1, d0);
        s4 = {pat(d3), pat(d2), pat(d1), pat(d0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        valid_cnt = 0; err_cnt = 0; valid_k = 0; err_k = 0;
    endtask

    // Drive one select/pattern at a negedge and sample outputs on each following negedge
    task automatic step(input logic [3:0] d, input logic [6:0] s, input int hold);
        bus.DIG = d;
        bus.SEG = s;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (bus.VALID) begin valid_cnt++; valid_k = k; end
            if (bus.ERR)   begin err_cnt++;   err_k = k;   end
            if (bus.VALID && bus.ERR) both_cnt++;
        end
    endtask

    task automatic scan_frame(input logic [3:0][6:0] segs, input int hold, input int frames);
        logic [3:0] d;
        for (int f = 0; f < frames; f++)
            for (int i = 0; i < 4; i++) begin
                d = 4'b0001 << i;
                step(d, segs[i], hold);
            end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit hit, expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][6:0] bs;
        logic [3:0][6:0] hx;
        logic [15:0]     cur;
        bs    = s4(9, 8, 7, 6);
        bs[2] = 7'b0000000;
        hx    = {4{7'b1110111}};

        tbl[0] = '{s4(4, 3, 2, 1), 20, 2, 16'h4321, 1, 0};
        tbl[1] = '{s4(4, 3, 2, 1), 20, 5, 16'h4321, 0, 0};
        tbl[2] = '{bs,             20, 1, 16'h4321, 0, 1};
        tbl[3] = '{s4(9, 8, 7, 6), 20, 2, 16'h9876, 1, 0};
        tbl[4] = '{s4(1, 1, 1, 1),  5, 3, 16'h9876, 0, 0};
        tbl[5] = '{s4(1, 1, 1, 1), 20, 1, 16'h9876, 0, 0};
        tbl[6] = '{s4(2, 2, 2, 2), 20, 1, 16'h9876, 0, 0};
        tbl[7] = '{s4(1, 1, 1, 1), 20, 1, 16'h9876, 0, 0};
        tbl[8] = '{s4(2, 2, 2, 2), 20, 1, 16'h9876, 0, 0};
`ifdef SEG7_HEX_EN
        tbl[9] = '{hx,             20, 2, 16'hAAAA, 1, 0};
`else
        tbl[9] = '{hx,             20, 2, 16'h9876, 0, 2};
`endif

        rst_n   = 1'b0;
        bus.DIG = '0;
        bus.SEG = '0;
        repeat (3) @(negedge clk);
        chk("reset VALUE", bus.VALUE, 0);
        chk("reset VALID", bus.VALID, 0);
        chk("reset ERR",   bus.ERR,   0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            clr();
            scan_frame(tbl[i].segs, tbl[i].hold, tbl[i].frames);
            chk($sformatf("v%0d VALUE", i), bus.VALUE, tbl[i].exp_value);
            chk($sformatf("v%0d VALID pulses", i), valid_cnt, tbl[i].exp_valid);
            chk($sformatf("v%0d ERR pulses", i), err_cnt, tbl[i].exp_err);
        end
        cur = tbl[9].exp_value;

        // Two-hot select held long must never capture; digits 0 and 3 alone can't complete
        clr();
        step(4'b0110, pat(8), 50);
        for (int r = 0; r < 2; r++) begin
            step(4'b0001, pat(8), 20);
            step(4'b1000, pat(8), 20);
        end
        chk("multi-hot VALUE", bus.VALUE, cur);
        chk("multi-hot VALID pulses", valid_cnt, 0);
        chk("multi-hot ERR pulses", err_cnt, 0);

        // Reset in the middle of a partial frame
        step(4'b0001, pat(7), 20);
        step(4'b0010, pat(7), 20);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid-reset VALUE", bus.VALUE, 0);
        chk("mid-reset VALID", bus.VALID, 0);
        chk("mid-reset ERR",   bus.ERR,   0);
        rst_n = 1'b1;

        // Fresh value after reset; VALID lands 10 negedges into the last select
        clr();
        scan_frame(s4(5, 5, 5, 5), 20, 1);
        chk("post-reset frame1 VALID pulses", valid_cnt, 0);
        scan_frame(s4(5, 5, 5, 5), 20, 1);
        chk("post-reset VALID pulses", valid_cnt, 1);
        chk("VALID latency", valid_k, 10);
        chk("post-reset VALUE", bus.VALUE, 16'h5555);
        chk("post-reset ERR pulses", err_cnt, 0);

        // Blank digit: ERR with the same latency, VALUE held
        clr();
        scan_frame(bs, 20, 1);
        chk("blank ERR pulses", err_cnt, 1);
        chk("ERR latency", err_k, 10);
        chk("blank VALUE", bus.VALUE, 16'h5555);
        chk("blank VALID pulses", valid_cnt, 0);

        chk("VALID and ERR together", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_reader.md
Name:
seg7_scan_reader

Overview:
- Receive-side counterpart of the team's BCD-to-7-segment decoder.
- Observes a multiplexed 7-segment display bus (segment pattern plus one-hot digit select) and decodes each pattern back to a 4-bit digit.
- Assembles a full multi-digit value and publishes it once it is stable across consecutive scan frames.
- Used as a loopback checker on display outputs and as a front end for reading external 7-segment panels.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; width of DIG and one nibble of VALUE per digit
SETTLE_CYCLES, 8, consecutive cycles a digit select must stay unchanged before SEG is sampled (1..255)
MATCH_FRAMES, 2, consecutive identical valid frames required before VALUE updates (1..15)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST_N  input  1  synchronous active-low reset
SEG  input  7  segment pattern, active-high, bit6=a ... bit0=g
DIG  input  NUM_DIGITS  digit select, active-high, one-hot when valid; bit i = digit i = VALUE nibble i
VALUE  output  4*NUM_DIGITS  last published value, one BCD (or hex) nibble per digit
VALID  output  1  one-cycle pulse when VALUE is updated
ERR  output  1  one-cycle pulse when a frame is discarded due to an undecodable pattern

Behaviour:
- Reset (RST_N=0 at a rising CLK edge):
  - VALUE=0, VALID=0, ERR=0.
  - Settle counter, captured-digit mask, frame buffer, bad-frame flag and match counter are cleared.
  - State returns to WAIT.
- Pattern table, inverse of the team decoder:
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4.
  - 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
  - Every other pattern, including blank 0000000, is invalid.
- States:
  - WAIT: DIG is not one-hot (zero or multiple bits). Hold the counter at 0.
  - SETTLE: DIG is one-hot. The counter increments every cycle while DIG equals its previous-cycle value. A change of DIG returns to WAIT if the new DIG is not one-hot, otherwise restarts SETTLE at count 0.
  - CAPTURE: entered on the cycle the counter reaches SETTLE_CYCLES-1.
    - SEG is decoded and written to frame nibble i; mask bit i is set.
    - An invalid pattern sets the bad-frame flag.
    - The machine then goes to HOLD.
  - HOLD: waits for DIG to change. No further capture of the same select occurs. On change, go to SETTLE or WAIT as above.
- Re-capturing a digit already in the mask within the same frame overwrites its nibble. The bad-frame flag is not cleared by the overwrite.
- Frame completion: the cycle after the mask becomes all ones.
  - Bad frame:
    - ERR pulses.
    - Match counter cleared.
    - VALUE unchanged.
  - Good frame, equal to the previous good frame: match counter increments, saturating at MATCH_FRAMES.
  - Good frame, not equal to the previous good frame: match counter set to 1.
  - When the match counter equals MATCH_FRAMES and the frame differs from VALUE:
    - VALUE loads the frame.
    - VALID pulses for exactly one cycle.
  - An identical republish gives no VALID pulse.
  - Mask and bad-frame flag are cleared in the same cycle. The frame buffer is retained for the comparison with the next frame.
- Latency: VALUE/VALID appear 2 cycles after the CAPTURE of the last digit of the qualifying frame. ERR obeys the same 2-cycle timing.
- VALID and ERR are never both high.
- Reset mid-frame discards all partial data. VALUE returns to 0.
- MATCH_FRAMES=1: every good frame that differs from VALUE publishes.

Optional Feature:
- Macro: SEG7_HEX_EN.
- Defined: additionally accept 1110111=A, 0011111=b, 1001110=C, 0111101=d, 1001111=E, 1000111=F as valid nibbles A..F.
- Undefined: those six patterns are invalid and cause frame discard and ERR.
- Blank remains invalid in both builds.

Test Plan:
- Reset then scan digits 0..3 with patterns for 1,2,3,4, each select held 20 cycles, two frames -> VALID single pulse, VALUE=16'h4321. ERR stays 0 throughout.
- Same scan continued for 5 more frames -> no further VALID pulses, VALUE stays 16'h4321.
- Frame with digit 2 showing 0000000 -> ERR pulses once 2 cycles after last capture, VALUE unchanged. The next two clean frames of 16'h9876 -> VALID, VALUE=16'h9876.
- DIG held 5 cycles per digit (< SETTLE_CYCLES=8) -> no captures, no VALID/ERR. DIG=4'b0110 held 50 cycles -> no capture.
- Alternating frames 16'h1111/16'h2222 -> match counter never reaches 2, no VALID. Assert RST_N=0 mid-frame -> next cycle VALUE=0, VALID=0, ERR=0.
- Pattern 1110111 on all digits for two frames -> with SEG7_HEX_EN: VALUE=16'hAAAA, VALID pulses. Without SEG7_HEX_EN: ERR pulses each frame.
